// File: rtl/sram_port0_ctrl_if.sv
// Request/response bundle between a datapath initiator and the port-0 SRAM controller.
// The initiator drives requests; the controller returns acceptance and read data.
interface sram_port0_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  req_ready, rdata, rvalid
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    output req_ready, rdata, rvalid
  );

endinterface

// File: rtl/sram_port0_ctrl.sv
// Port-0 (1RW) controller for the 32x256 OpenRAM macro: registered macro signalling,
// two-cycle read return, and a sequencer that writes CLEAR_VALUE to every word.
module sram_port0_ctrl #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    NUM_WMASKS  = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_port0_ctrl_if.slave      req,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RAM_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0]            rd_tag_q, rd_tag_d;
  logic                  rd_issue;
  logic                  accept;

  logic                  csb_d, web_d, busy_d, done_d, rvalid_d;
  logic [NUM_WMASKS-1:0] wmask_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d, rdata_d;

  // A same-cycle clear_start wins over any pending request.
  assign req.req_ready = (state_q == S_IDLE) && !clear_start;
  assign accept        = req.req_valid && req.req_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    csb_d    = 1'b1;
    web_d    = 1'b1;
    wmask_d  = sram_wmask0;
    addr_d   = sram_addr0;
    din_d    = sram_din0;
    done_d   = 1'b0;
    rd_issue = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (accept) begin
          csb_d  = 1'b0;
          web_d  = !req.req_we;
          addr_d = req.req_addr;
          if (req.req_we) begin
            din_d   = req.req_wdata;
            wmask_d = req.req_wmask;
          end else begin
            wmask_d  = '0;
            rd_issue = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        addr_d  = cnt_q[ADDR_WIDTH-1:0];
        din_d   = CLEAR_VALUE;
        wmask_d = '1;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CLEAR);
  end

  // Read tags advance one stage per cycle; the macro's output is valid two edges after acceptance.
  always_comb begin
    rd_tag_d = {rd_tag_q[0], rd_issue};
    rvalid_d = rd_tag_q[1];
    rdata_d  = rd_tag_q[1] ? sram_dout0 : req.rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_tag_q    <= '0;
      busy        <= 1'b0;
      clear_done  <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      req.rdata   <= '0;
      req.rvalid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_tag_q    <= rd_tag_d;
      busy        <= busy_d;
      clear_done  <= done_d;
      sram_csb0   <= csb_d;
      sram_web0   <= web_d;
      sram_wmask0 <= wmask_d;
      sram_addr0  <= addr_d;
      sram_din0   <= din_d;
      req.rdata   <= rdata_d;
      req.rvalid  <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Directed bench for sram_port0_ctrl with a behavioural 1RW macro model
// (inputs latched at posedge, write commit / read output at negedge).
module tb_sram_port0_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_start;
  logic          busy, clear_done;
  logic          sram_csb0, sram_web0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  always #5 clk = ~clk;

  sram_port0_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) bus ();

  sram_port0_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_WMASKS (NW),
    .CLEAR_VALUE('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus.slave),
    .clear_start(clear_start),
    .busy       (busy),
    .clear_done (clear_done),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  // Macro model
  logic [DW-1:0] mem [256];
  logic          m_csb, m_web;
  logic [NW-1:0] m_wmask;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  initial begin
    m_csb      = 1'b1;
    m_web      = 1'b1;
    sram_dout0 = '0;
  end

  always @(posedge clk) begin
    m_csb   <= sram_csb0;
    m_web   <= sram_web0;
    m_wmask <= sram_wmask0;
    m_addr  <= sram_addr0;
    m_din   <= sram_din0;
  end

  always @(negedge clk) begin
    if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < NW; b++)
          if (m_wmask[b]) mem[m_addr][b*8 +: 8] <= m_din[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[m_addr];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request, confirm it is acceptable, and let one edge take it.
  task automatic do_req(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    #1;
    check("req_ready", 32'(bus.req_ready), 32'd1);
    cycle();
    bus.req_valid = 1'b0;
  endtask

  // Read accepted at edge N: rvalid low after N and N+1, high with data after N+2, low after N+3.
  task automatic rd_expect(input string tag, input logic [7:0] a, input logic [31:0] exp);
    do_req(1'b0, a, 32'h0, 4'h0);
    check({tag, "_rvalid_n0"}, 32'(bus.rvalid), 32'd0);
    cycle();
    check({tag, "_rvalid_n1"}, 32'(bus.rvalid), 32'd0);
    cycle();
    check({tag, "_rvalid_n2"}, 32'(bus.rvalid), 32'd1);
    check({tag, "_rdata"}, bus.rdata, exp);
    cycle();
    check({tag, "_rvalid_n3"}, 32'(bus.rvalid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_csb0"},   32'(sram_csb0),   32'd1);
    check({tag, "_web0"},   32'(sram_web0),   32'd1);
    check({tag, "_wmask0"}, 32'(sram_wmask0), 32'd0);
    check({tag, "_addr0"},  32'(sram_addr0),  32'd0);
    check({tag, "_din0"},   sram_din0,        32'd0);
    check({tag, "_rdata"},  bus.rdata,        32'd0);
    check({tag, "_rvalid"}, 32'(bus.rvalid),  32'd0);
    check({tag, "_busy"},   32'(busy),        32'd0);
    check({tag, "_done"},   32'(clear_done),  32'd0);
  endtask

  int  busy_cyc, wr_cnt, done_cnt, ready_bad, seq_bad;
  logic found;

  initial begin
    rst           = 1'b1;
    clear_start   = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;

    // Reset state, before any clock edge
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Full-mask write, then read with exact latency
    do_req(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    check("wr_csb0", 32'(sram_csb0), 32'd0);
    check("wr_web0", 32'(sram_web0), 32'd0);
    check("wr_addr0", 32'(sram_addr0), 32'h10);
    rd_expect("t1", 8'h10, 32'hDEADBEEF);

    // Byte-masked write merges with the old word
    do_req(1'b1, 8'h20, 32'hFFFFFFFF, 4'hF);
    do_req(1'b1, 8'h20, 32'h00000000, 4'b0101);
    rd_expect("t2", 8'h20, 32'hFF00FF00);

    // Zero-mask write still selects the macro but changes nothing
    do_req(1'b1, 8'h20, 32'h12345678, 4'h0);
    check("wm0_csb0", 32'(sram_csb0), 32'd0);
    check("wm0_web0", 32'(sram_web0), 32'd0);
    check("wm0_wmask0", 32'(sram_wmask0), 32'd0);
    check("wm0_din0", sram_din0, 32'h12345678);
    rd_expect("t2b", 8'h20, 32'hFF00FF00);
    check("rd_din0_hold", sram_din0, 32'h12345678);
    check("idle_csb0", 32'(sram_csb0), 32'd1);

    // Back-to-back reads return in order on consecutive cycles
    do_req(1'b1, 8'h00, 32'h11, 4'hF);
    do_req(1'b1, 8'h01, 32'h22, 4'hF);
    do_req(1'b1, 8'h02, 32'h33, 4'hF);
    do_req(1'b0, 8'h00, 32'h0, 4'h0);
    do_req(1'b0, 8'h01, 32'h0, 4'h0);
    do_req(1'b0, 8'h02, 32'h0, 4'h0);
    check("b2b_rvalid0", 32'(bus.rvalid), 32'd1);
    check("b2b_rdata0", bus.rdata, 32'h11);
    cycle();
    check("b2b_rvalid1", 32'(bus.rvalid), 32'd1);
    check("b2b_rdata1", bus.rdata, 32'h22);
    cycle();
    check("b2b_rvalid2", 32'(bus.rvalid), 32'd1);
    check("b2b_rdata2", bus.rdata, 32'h33);
    cycle();
    check("b2b_rvalid3", 32'(bus.rvalid), 32'd0);

    // Write immediately followed by read of the same address
    do_req(1'b1, 8'h05, 32'hA5A5A5A5, 4'hF);
    rd_expect("t5", 8'h05, 32'hA5A5A5A5);

    // Clear with a request held high; a second clear_start mid-way is ignored
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'hFF;
    clear_start   = 1'b1;
    #1;
    check("clr_ready_prio", 32'(bus.req_ready), 32'd0);
    cycle();
    clear_start = 1'b0;
    busy_cyc = 0; wr_cnt = 0; done_cnt = 0; ready_bad = 0; seq_bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 50) clear_start = 1'b1;
      if (i == 51) clear_start = 1'b0;
      if (busy) begin
        busy_cyc++;
        if (bus.req_ready) ready_bad++;
      end
      if (!sram_csb0 && !sram_web0) begin
        if (sram_addr0 != wr_cnt[7:0] || sram_din0 != 32'h0 || sram_wmask0 != 4'hF) seq_bad++;
        wr_cnt++;
      end
      if (clear_done) done_cnt++;
      if (!busy) bus.req_valid = 1'b0;
      cycle();
    end
    bus.req_valid = 1'b0;
    check("clr_busy_cycles", 32'(busy_cyc), 32'd256);
    check("clr_writes", 32'(wr_cnt), 32'd256);
    check("clr_done_pulses", 32'(done_cnt), 32'd1);
    check("clr_ready_low", 32'(ready_bad), 32'd0);
    check("clr_write_seq", 32'(seq_bad), 32'd0);
    rd_expect("clr_ff", 8'hFF, 32'h0);
    rd_expect("clr_10", 8'h10, 32'h0);
    rd_expect("clr_05", 8'h05, 32'h0);

    // Reset mid-clear, with a read issued just before the clear
    do_req(1'b1, 8'd0,   32'h0BAD0000, 4'hF);
    do_req(1'b1, 8'd99,  32'h0BAD0063, 4'hF);
    do_req(1'b1, 8'd100, 32'h0BAD0064, 4'hF);
    do_req(1'b1, 8'd150, 32'h0BAD0096, 4'hF);
    do_req(1'b1, 8'd200, 32'hCAFEF00D, 4'hF);
    do_req(1'b0, 8'd200, 32'h0, 4'h0);
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    cycle();
    check("inflight_rvalid", 32'(bus.rvalid), 32'd1);
    check("inflight_rdata", bus.rdata, 32'hCAFEF00D);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!sram_csb0 && sram_addr0 == 8'd100) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("reach_addr100", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_clr");
    check("rst_clr_ready", 32'(bus.req_ready), 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (clear_done || busy) done_cnt++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (clear_done || busy) done_cnt++;
    end
    check("rst_clr_no_done", 32'(done_cnt), 32'd0);
    rd_expect("part_0",   8'd0,   32'h0);
    rd_expect("part_99",  8'd99,  32'h0);
    rd_expect("part_100", 8'd100, 32'h0BAD0064);
    rd_expect("part_150", 8'd150, 32'h0BAD0096);
    rd_expect("part_200", 8'd200, 32'hCAFEF00D);

    // Reset with a read in flight drops it
    do_req(1'b0, 8'd200, 32'h0, 4'h0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_rd");
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (bus.rvalid) done_cnt++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (bus.rvalid) done_cnt++;
    end
    check("rst_rd_no_rvalid", 32'(done_cnt), 32'd0);
    rd_expect("post_rst", 8'd200, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
